// File: rtl/parity_check_arbiter_pkg.sv
// Shared definitions for the parity-check arbiter: parity mode constants, output-slot
// state type and elaboration-time helpers.
package parity_check_arbiter_pkg;

  localparam int unsigned PARITY_EVEN = 0;
  localparam int unsigned PARITY_ODD  = 1;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } slot_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Bit XORed into the data/pbit reduction so that a correct word yields error = 0.
  function automatic logic parity_mode_bit(input int unsigned mode);
    return (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/parity_check_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found searching upward
// from i_last_grant + 1, wrapping; the grant is one-hot or zero.
module parity_check_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant
);

  logic w_found;

  // Two passes: indices above the last grant first, then wrap to the low indices.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    if (i_enable) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!w_found && i_req[i] && (i > int'(i_last_grant))) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!w_found && i_req[i]) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/parity_check_arbiter.sv
// Shares one even-parity checker among NUM_REQ requesters through a round-robin arbiter,
// holding each result in a single-entry output slot and counting parity errors.
module parity_check_arbiter
  import parity_check_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_pbit,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ID_W-1:0]             res_id,
  output logic [DATA_W-1:0]           res_data,
  output logic                        res_pbit,
  output logic                        res_error,
  input  logic                        clear_count,
  output logic [CNT_W-1:0]            err_count
);

  localparam logic ParityMode = parity_mode_bit(PARITY_EVEN);

  if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end
  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end

  slot_state_e       r_state;
  slot_state_e       w_state_next;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic              r_pbit;
  logic              r_error;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;

  logic               w_slot_free;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic               w_err_evt;
  logic [ID_W-1:0]    w_sel_id;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_pbit;
  logic               w_sel_error;

  // A full slot that is being drained this cycle can be refilled in the same cycle.
  assign w_slot_free = (r_state == StEmpty) || res_ready;

  parity_check_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (w_slot_free),
    .o_grant      (w_grant)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  always_comb begin
    w_sel_id   = '0;
    w_sel_data = '0;
    w_sel_pbit = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_id   = ID_W'(i);
        w_sel_data = req_data[i*DATA_W +: DATA_W];
        w_sel_pbit = req_pbit[i];
      end
    end
  end

  assign w_sel_error = (^w_sel_data) ^ w_sel_pbit ^ ParityMode;
  assign w_err_evt   = w_xfer && w_sel_error;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StEmpty: if (w_xfer) w_state_next = StFull;
      StFull:  if (res_ready && !w_xfer) w_state_next = StEmpty;
      default: w_state_next = StEmpty;
    endcase
  end

  // A clear that coincides with an erroring transfer keeps that event as a count of one.
  always_comb begin
    w_count_next = r_count;
    if (clear_count) begin
      w_count_next = CNT_W'(w_err_evt);
    end else if (w_err_evt && (r_count != '1)) begin
      w_count_next = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StEmpty;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_data       <= '0;
      r_pbit       <= 1'b0;
      r_error      <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_xfer) begin
        r_id         <= w_sel_id;
        r_data       <= w_sel_data;
        r_pbit       <= w_sel_pbit;
        r_error      <= w_sel_error;
        r_last_grant <= w_sel_id;
      end
    end
  end

  assign res_valid = (r_state == StFull);
  assign res_id    = r_id;
  assign res_data  = r_data;
  assign res_pbit  = r_pbit;
  assign res_error = r_error;
  assign err_count = r_count;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Randomised and directed bench for parity_check_arbiter with a queue-based scoreboard
// fed by a behavioural model and drained by an independent output monitor.
module tb_parity_check_arbiter;

  localparam int NR = 4;
  localparam int DW = 4;
  localparam int CW = 2;
  localparam int IW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_pbit;
  logic             res_valid;
  logic             res_ready;
  logic [IW-1:0]    res_id;
  logic [DW-1:0]    res_data;
  logic             res_pbit;
  logic             res_error;
  logic             clear_count;
  logic [CW-1:0]    err_count;

  parity_check_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .CNT_W   (CW),
    .ID_W    (IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_pbit    (req_pbit),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_data    (res_data),
    .res_pbit    (res_pbit),
    .res_error   (res_error),
    .clear_count (clear_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int pbit;
    int err;
  } res_t;

  res_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: what the DUT should hold after the most recent edge.
  int m_last  = NR - 1;
  bit m_full  = 1'b0;
  int m_cnt   = 0;
  bit m_fresh = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle when inputs are stable, then advanced past the
  // coming edge.
  initial begin
    logic [NR-1:0] exp_grant;
    int            xfer;
    int            d;
    int            p;
    int            e;
    res_t          r;
    forever begin
      @(negedge clk);
      exp_grant = '0;
      if (!m_full || res_ready) begin
        for (int k = 1; k <= NR; k++) begin
          if (req_valid[(m_last + k) % NR]) begin
            exp_grant[(m_last + k) % NR] = 1'b1;
            break;
          end
        end
      end
      check("req_ready", int'(req_ready), int'(exp_grant));
      check("res_valid", int'(res_valid), int'(m_full));
      check("err_count", int'(err_count), m_cnt);
      if (m_fresh) begin
        check("res_regs_after_reset", int'({res_id, res_data, res_pbit, res_error}), 0);
      end

      if (!rst_n) begin
        m_full  = 1'b0;
        m_last  = NR - 1;
        m_cnt   = 0;
        m_fresh = 1'b1;
        q.delete();
      end else begin
        xfer = -1;
        e    = 0;
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && exp_grant[i]) xfer = i;
        end
        if (xfer >= 0) begin
          d      = int'(req_data[xfer*DW +: DW]);
          p      = int'(req_pbit[xfer]);
          e      = ($countones(d) + p) % 2;
          r.id   = xfer;
          r.data = d;
          r.pbit = p;
          r.err  = e;
          q.push_back(r);
          m_full  = 1'b1;
          m_last  = xfer;
          m_fresh = 1'b0;
        end else if (res_ready) begin
          m_full = 1'b0;
        end
        if (clear_count) begin
          m_cnt = (xfer >= 0 && e == 1) ? 1 : 0;
        end else if (xfer >= 0 && e == 1 && m_cnt < CNT_MAX) begin
          m_cnt++;
        end
      end
    end
  end

  // Output monitor: the held result must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("res_id", int'(res_id), q[0].id);
          check("res_data", int'(res_data), q[0].data);
          check("res_pbit", int'(res_pbit), q[0].pbit);
          check("res_error", int'(res_error), q[0].err);
          if (res_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // One cycle; accepted words are withdrawn unless the edge was a reset edge.
  task automatic step();
    logic [NR-1:0] acc;
    logic          rst_seen;
    @(negedge clk);
    acc      = req_valid & req_ready;
    rst_seen = rst_n;
    @(posedge clk);
    #1;
    if (rst_seen) req_valid = req_valid & ~acc;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] d, input logic p);
    req_data[i*DW +: DW] = d;
    req_pbit[i]          = p;
    req_valid[i]         = 1'b1;
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < NR; i++) begin
      if (!req_valid[i] && ($urandom_range(0, 99) < pct)) begin
        set_word(i, DW'($urandom), 1'($urandom));
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_pbit    = '0;
    res_ready   = 1'b0;
    clear_count = 1'b0;

    // Reset then idle.
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Single requester: clean word, then an erroring word.
    res_ready = 1'b1;
    set_word(2, 4'b0011, 1'b0);
    step();
    step();
    set_word(2, 4'b0111, 1'b0);
    step();
    step();

    // Round-robin fairness from a fresh pointer.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      refill(100);
      step();
    end

    // Backpressure while full, then release.
    res_ready = 1'b0;
    repeat (3) step();
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      refill(100);
      step();
    end

    // Counter saturation and clear.
    req_valid = '0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_word(1, 4'b1111, 1'b1);
      step();
    end
    step();
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    step();
    set_word(3, 4'b1111, 1'b1);
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    step();

    // Reset while holding a result from requester 1.
    res_ready = 1'b0;
    set_word(1, 4'b0101, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    refill(100);
    step();
    step();

    // Random traffic with backpressure, clears and occasional resets.
    for (int c = 0; c < 600; c++) begin
      res_ready   = ($urandom_range(0, 3) != 0);
      clear_count = ($urandom_range(0, 49) == 0);
      rst_n       = ($urandom_range(0, 99) != 0);
      refill(40);
      step();
    end
    rst_n       = 1'b1;
    clear_count = 1'b0;

    // Drain everything outstanding.
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) step();
    check("drain_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
